control: RTL and testbench

CONTROL -- requirements
Module: control

---
 rtl/control_pkg.sv | 69 ++++++
 rtl/control_decode.sv | 102 ++++++++++
 rtl/control.sv | 72 +++++++
 tb/tb_control.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// ============================================================================
//  Module      : control_pkg
//  Description : Shared constants for the instruction control decoder:
//                opcode values, R-type func values, ALU operation encodings
//                and the packed control-word type carried between the
//                combinational decoder and the output register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package control_pkg;

    // Opcodes, instruction bits [31:26]
    localparam logic [5:0] C_OP_RTYPE = 6'b000000;
    localparam logic [5:0] C_OP_J     = 6'b000010;
    localparam logic [5:0] C_OP_JAL   = 6'b000011;
    localparam logic [5:0] C_OP_BEQ   = 6'b000100;
    localparam logic [5:0] C_OP_BNE   = 6'b000101;
    localparam logic [5:0] C_OP_ADDI  = 6'b001000;
    localparam logic [5:0] C_OP_SLTI  = 6'b001010;
    localparam logic [5:0] C_OP_ANDI  = 6'b001100;
    localparam logic [5:0] C_OP_ORI   = 6'b001101;
    localparam logic [5:0] C_OP_LI    = 6'b001111;
    localparam logic [5:0] C_OP_LW    = 6'b100011;
    localparam logic [5:0] C_OP_SW    = 6'b101011;

    // R-type func codes, instruction bits [5:0]
    localparam logic [5:0] C_FN_SLL   = 6'b000000;
    localparam logic [5:0] C_FN_SRL   = 6'b000010;
    localparam logic [5:0] C_FN_JR    = 6'b001000;
    localparam logic [5:0] C_FN_MULT  = 6'b011000;
    localparam logic [5:0] C_FN_ADD   = 6'b100000;
    localparam logic [5:0] C_FN_SUB   = 6'b100010;
    localparam logic [5:0] C_FN_AND   = 6'b100100;
    localparam logic [5:0] C_FN_OR    = 6'b100101;
    localparam logic [5:0] C_FN_SLT   = 6'b101010;

    // ALU operation encoding
    localparam logic [2:0] C_ALU_ADD  = 3'b000;
    localparam logic [2:0] C_ALU_SUB  = 3'b001;
    localparam logic [2:0] C_ALU_AND  = 3'b010;
    localparam logic [2:0] C_ALU_OR   = 3'b011;
    localparam logic [2:0] C_ALU_SLT  = 3'b100;
    localparam logic [2:0] C_ALU_MULT = 3'b101;
    localparam logic [2:0] C_ALU_SLL  = 3'b110;
    localparam logic [2:0] C_ALU_SRL  = 3'b111;

    // Full control word; an all-zero value is the NOP pattern.
    typedef struct packed {
        logic       regDst;
        logic       aluSrc;
        logic       memToReg;
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic       branch;
        logic       branchNot;
        logic       jump;
        logic       jumpAndLink;
        logic       jumpReg;
        logic       loadImm;
        logic [2:0] aluOp;
    } ctrl_t;

    localparam ctrl_t C_CTRL_NOP = '0;

endpackage : control_pkg

`default_nettype wire

// File: rtl/control_decode.sv
// ============================================================================
//  Module      : control_decode
//  Description : Purely combinational instruction decoder. Maps opcode/func
//                to a full control word; unlisted encodings produce NOP.
//  Ports       : opcode_i  [5:0] instruction bits [31:26]
//                func_i    [5:0] instruction bits [5:0] (R-type only)
//                ctrl_o    ctrl_t decoded control word
//  Config      : CONTROL_MULT_EN - when defined, R-type func 011000 decodes
//                as mult; otherwise it is a NOP and aluOp 101 never appears.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_decode
    import control_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] func_i,
    output ctrl_t      ctrl_o
);

    // Shared shape of every register-to-register ALU instruction.
    function automatic ctrl_t f_rtype_alu(input logic [2:0] op);
        ctrl_t c;
        c          = C_CTRL_NOP;
        c.regDst   = 1'b1;
        c.regWrite = 1'b1;
        c.aluOp    = op;
        return c;
    endfunction

    // Shared shape of the immediate ALU instructions.
    function automatic ctrl_t f_imm_alu(input logic [2:0] op);
        ctrl_t c;
        c          = C_CTRL_NOP;
        c.aluSrc   = 1'b1;
        c.regWrite = 1'b1;
        c.aluOp    = op;
        return c;
    endfunction

    always_comb begin
        ctrl_o = C_CTRL_NOP;
        unique case (opcode_i)
            C_OP_RTYPE: begin
                // func is only consulted here; every other opcode ignores it.
                case (func_i)
                    C_FN_ADD:  ctrl_o = f_rtype_alu(C_ALU_ADD);
                    C_FN_SUB:  ctrl_o = f_rtype_alu(C_ALU_SUB);
                    C_FN_AND:  ctrl_o = f_rtype_alu(C_ALU_AND);
                    C_FN_OR:   ctrl_o = f_rtype_alu(C_ALU_OR);
                    C_FN_SLT:  ctrl_o = f_rtype_alu(C_ALU_SLT);
                    C_FN_SLL:  ctrl_o = f_rtype_alu(C_ALU_SLL);
                    C_FN_SRL:  ctrl_o = f_rtype_alu(C_ALU_SRL);
`ifdef CONTROL_MULT_EN
                    C_FN_MULT: ctrl_o = f_rtype_alu(C_ALU_MULT);
`endif
                    C_FN_JR:   ctrl_o.jumpReg = 1'b1;
                    default:   ctrl_o = C_CTRL_NOP;
                endcase
            end
            C_OP_LW: begin
                ctrl_o.aluSrc   = 1'b1;
                ctrl_o.memToReg = 1'b1;
                ctrl_o.regWrite = 1'b1;
                ctrl_o.memRead  = 1'b1;
            end
            C_OP_SW: begin
                ctrl_o.aluSrc   = 1'b1;
                ctrl_o.memWrite = 1'b1;
            end
            C_OP_BEQ: begin
                ctrl_o.branch = 1'b1;
                ctrl_o.aluOp  = C_ALU_SUB;
            end
            C_OP_BNE: begin
                ctrl_o.branchNot = 1'b1;
                ctrl_o.aluOp     = C_ALU_SUB;
            end
            C_OP_J: begin
                ctrl_o.jump = 1'b1;
            end
            C_OP_JAL: begin
                ctrl_o.jump        = 1'b1;
                ctrl_o.jumpAndLink = 1'b1;
                ctrl_o.regWrite    = 1'b1;
            end
            C_OP_ADDI: ctrl_o = f_imm_alu(C_ALU_ADD);
            C_OP_ANDI: ctrl_o = f_imm_alu(C_ALU_AND);
            C_OP_ORI:  ctrl_o = f_imm_alu(C_ALU_OR);
            C_OP_SLTI: ctrl_o = f_imm_alu(C_ALU_SLT);
            C_OP_LI: begin
                ctrl_o          = f_imm_alu(C_ALU_ADD);
                ctrl_o.loadImm  = 1'b1;
            end
            default: ctrl_o = C_CTRL_NOP;
        endcase
    end

endmodule : control_decode

`default_nettype wire

// File: rtl/control.sv
// ============================================================================
//  Module      : control
//  Description : Registered instruction control unit. The decode of
//                opcode/func sampled at a rising edge appears on the outputs
//                after that edge and is held for one cycle. Synchronous
//                active-high rst forces the NOP pattern and wins over decode.
//  Ports       : clk, rst                      clock / sync reset
//                opcode[5:0], func[5:0]        instruction fields
//                regDst, aluSrc, memToReg, regWrite, memRead, memWrite,
//                branch, branchNot, jump, jumpAndLink, jumpReg, loadImm
//                aluOp[2:0]                    registered control outputs
//  Config      : CONTROL_MULT_EN - enables R-type mult decode (aluOp 101).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control
    import control_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    output logic       regDst,
    output logic       aluSrc,
    output logic       memToReg,
    output logic       regWrite,
    output logic       memRead,
    output logic       memWrite,
    output logic       branch,
    output logic       branchNot,
    output logic       jump,
    output logic       jumpAndLink,
    output logic       jumpReg,
    output logic       loadImm,
    output logic [2:0] aluOp
);

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    control_decode u_decode (
        .opcode_i (opcode),
        .func_i   (func),
        .ctrl_o   (ctrl_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= C_CTRL_NOP;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign regDst      = ctrl_q.regDst;
    assign aluSrc      = ctrl_q.aluSrc;
    assign memToReg    = ctrl_q.memToReg;
    assign regWrite    = ctrl_q.regWrite;
    assign memRead     = ctrl_q.memRead;
    assign memWrite    = ctrl_q.memWrite;
    assign branch      = ctrl_q.branch;
    assign branchNot   = ctrl_q.branchNot;
    assign jump        = ctrl_q.jump;
    assign jumpAndLink = ctrl_q.jumpAndLink;
    assign jumpReg     = ctrl_q.jumpReg;
    assign loadImm     = ctrl_q.loadImm;
    assign aluOp       = ctrl_q.aluOp;

endmodule : control

`default_nettype wire

// File: tb/tb_control.sv
// ============================================================================
//  Module      : tb_control
//  Description : Self-checking bench for control. Directed instruction
//                sequences followed by random opcode/func/rst traffic, each
//                compared against a mnemonic-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] func = '0;
    logic       regDst, aluSrc, memToReg, regWrite, memRead, memWrite;
    logic       branch, branchNot, jump, jumpAndLink, jumpReg, loadImm;
    logic [2:0] aluOp;

    int checks = 0;
    int failed = 0;
    int passed = 0;

    always #5 clk = ~clk;

    control dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .func        (func),
        .regDst      (regDst),
        .aluSrc      (aluSrc),
        .memToReg    (memToReg),
        .regWrite    (regWrite),
        .memRead     (memRead),
        .memWrite    (memWrite),
        .branch      (branch),
        .branchNot   (branchNot),
        .jump        (jump),
        .jumpAndLink (jumpAndLink),
        .jumpReg     (jumpReg),
        .loadImm     (loadImm),
        .aluOp       (aluOp)
    );

    // Observed vector order:
    // regDst aluSrc memToReg regWrite memRead memWrite branch branchNot
    // jump jumpAndLink jumpReg loadImm aluOp[2:0]
    function automatic logic [14:0] observed();
        return {regDst, aluSrc, memToReg, regWrite, memRead, memWrite,
                branch, branchNot, jump, jumpAndLink, jumpReg, loadImm, aluOp};
    endfunction

    // Builds a control word from named flags.
    function automatic logic [14:0] pat(input string flags, input int alu);
        logic [14:0] v;
        v = '0;
        for (int i = 0; i < flags.len(); i++) begin
            case (flags[i])
                "D": v[14] = 1'b1;  // regDst
                "S": v[13] = 1'b1;  // aluSrc
                "M": v[12] = 1'b1;  // memToReg
                "W": v[11] = 1'b1;  // regWrite
                "R": v[10] = 1'b1;  // memRead
                "V": v[9]  = 1'b1;  // memWrite
                "B": v[8]  = 1'b1;  // branch
                "N": v[7]  = 1'b1;  // branchNot
                "J": v[6]  = 1'b1;  // jump
                "L": v[5]  = 1'b1;  // jumpAndLink
                "Q": v[4]  = 1'b1;  // jumpReg
                "I": v[3]  = 1'b1;  // loadImm
                default: ;
            endcase
        end
        v[2:0] = alu[2:0];
        return v;
    endfunction

    // Reference model: R-type func table indexed by the ALU operation number
    // (add, sub, and, or, slt, mult, sll, srl), then an opcode table.
    function automatic logic [14:0] model(input logic [5:0] op, input logic [5:0] fn);
        int rfunc [8] = '{32, 34, 36, 37, 42, 24, 0, 2};
        if (op == 0) begin
            if (fn == 8) return pat("Q", 0);
            for (int k = 0; k < 8; k++) begin
                if (int'(fn) == rfunc[k]) begin
`ifndef CONTROL_MULT_EN
                    if (k == 5) return '0;
`endif
                    return pat("DW", k);
                end
            end
            return '0;
        end
        case (int'(op))
            35: return pat("SMWR", 0); // lw
            43: return pat("SV", 0);   // sw
            4:  return pat("B", 1);    // beq
            5:  return pat("N", 1);    // bne
            2:  return pat("J", 0);    // j
            3:  return pat("JLW", 0);  // jal
            8:  return pat("SW", 0);   // addi
            12: return pat("SW", 2);   // andi
            13: return pat("SW", 3);   // ori
            10: return pat("SW", 4);   // slti
            15: return pat("ISW", 0);  // li
            default: return '0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [14:0] obs, input logic [14:0] exp);
        checks++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one instruction for one edge, then check the registered result
    // and the mutual-exclusion properties of the outputs.
    task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn,
                        input string tag);
        logic [14:0] exp;
        int          ctl;
        @(negedge clk);
        rst    = r;
        opcode = op;
        func   = fn;
        exp    = r ? 15'd0 : model(op, fn);
        @(posedge clk);
        #1;
        check(tag, observed(), exp);
        ctl = int'(branch) + int'(branchNot) + int'(jump) + int'(jumpReg);
        checks++;
        assert (ctl <= 1 && !(memRead && memWrite)) else begin
            failed++;
            $error("FAIL %s_excl observed=%b expected=exclusive", tag, observed());
        end
    endtask

    logic [5:0] seq_ops [11] = '{6'b100011, 6'b101011, 6'b000100, 6'b000101,
                                 6'b000010, 6'b000011, 6'b001000, 6'b001100,
                                 6'b001101, 6'b001010, 6'b001111};
    logic [5:0] rfn [10] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                             6'b101010, 6'b011000, 6'b000000, 6'b000010,
                             6'b001000, 6'b111111};

    initial begin
        // Reset held for two edges with lw applied, then release.
        step(1'b1, 6'b100011, 6'b000000, "reset0");
        step(1'b1, 6'b100011, 6'b000000, "reset1");
        step(1'b0, 6'b100011, 6'b000000, "lw_after_reset");

        // Direct spot checks against literal expectations.
        step(1'b0, 6'b000000, 6'b100010, "sub");
        check("sub_lit", observed(), 15'b100100000000001);
        step(1'b0, 6'b000000, 6'b001000, "jr");
        check("jr_lit", observed(), 15'b000000000010000);
        step(1'b0, 6'b000000, 6'b000010, "srl");
        step(1'b0, 6'b000000, 6'b000000, "sll");
        step(1'b0, 6'b111111, 6'b000000, "nop_op");
        step(1'b0, 6'b000000, 6'b111111, "nop_func");
        step(1'b0, 6'b000000, 6'b011000, "mult");

        // Back-to-back non-R-type instructions, with junk func to show it is ignored.
        for (int i = 0; i < 11; i++) begin
            step(1'b0, seq_ops[i], 6'($urandom), $sformatf("seq%0d", i));
        end

        // Reset mid-stream discards the instruction at that edge.
        step(1'b1, 6'b000011, 6'b000000, "reset_prio");
        step(1'b0, 6'b101011, 6'b000000, "sw_after_reset");

        // Random traffic biased towards valid encodings.
        for (int i = 0; i < 300; i++) begin
            logic       r;
            logic [5:0] op;
            logic [5:0] fn;
            r = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 2))
                0:       op = seq_ops[$urandom_range(0, 10)];
                1:       op = 6'b000000;
                default: op = 6'($urandom);
            endcase
            fn = ($urandom_range(0, 3) != 0) ? rfn[$urandom_range(0, 9)] : 6'($urandom);
            step(r, op, fn, $sformatf("rnd%0d", i));
        end

        passed = checks - failed;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_control

`default_nettype wire
